// File: rtl/arb_merge3_pkg.sv
// Shared types and constants for the three-way merge arbiter.
// Latency: none (declarations only).
// Backpressure: not applicable.
package arb_merge3_pkg;

   localparam int         NUM_REQ  = 3;
   localparam logic [1:0] SEL_NONE = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FIRE0,
      ST_GAP0,
      ST_FIRE1,
      ST_GAP1,
      ST_DRIVE,
      ST_FREE
   } state_t;

   // Modulo-3 increment of a requester index; SEL_NONE folds back to 0.
   function automatic logic [1:0] next_idx(input logic [1:0] idx);
      return (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
   endfunction

endpackage

// File: rtl/rr_pick3.sv
// Round-robin pick among three requesters, searching ptr, ptr+1, ptr+2 (mod 3).
// Latency: purely combinational.
// Backpressure: none; the caller decides when to take the pick.
module rr_pick3
   import arb_merge3_pkg::*;
(
   input  logic [2:0] request,
   input  logic [1:0] ptr,
   output logic       valid,
   output logic [1:0] index
);

   logic [1:0] cand0;
   logic [1:0] cand1;
   logic [1:0] cand2;

   // Walk candidates from lowest to highest priority so the first candidate wins.
   always_comb begin
      cand0 = (ptr == SEL_NONE) ? 2'd0 : ptr;
      cand1 = next_idx(cand0);
      cand2 = next_idx(cand1);
      valid = |request;
      index = SEL_NONE;
      if (request[cand2]) index = cand2;
      if (request[cand1]) index = cand1;
      if (request[cand0]) index = cand0;
   end

endmodule

// File: rtl/arb_merge3_ctrl.sv
// Three-requester merge controller: grant, fire two register stages, hand off downstream.
// Latency: grant->fire0 1 cycle, fire1 after FIRE_GAP idle cycles, driveNext FIRE_GAP cycles later.
// Backpressure: holds o_driveNext until i_freeNext; requesters wait on i_drive until o_free.
module arb_merge3_ctrl
   import arb_merge3_pkg::*;
#(
   parameter int FIRE_GAP = 0
)
(
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] i_drive,
   output logic [2:0] o_free,
   output logic       o_driveNext,
   input  logic       i_freeNext,
   output logic [1:0] o_fire_2,
   output logic [1:0] o_sel
);

   localparam logic [3:0] GAP_LOAD = 4'(FIRE_GAP);

   state_t     state;
   logic [1:0] ptr;
   logic [3:0] gap_cnt;
   logic       pick_vld;
   logic [1:0] pick_idx;

   rr_pick3 u_pick (
      .request (i_drive),
      .ptr     (ptr),
      .valid   (pick_vld),
      .index   (pick_idx)
   );

   // Single sequencer: every output is registered and changes only on a state transition.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         ptr         <= 2'd0;
         gap_cnt     <= 4'd0;
         o_free      <= 3'b000;
         o_driveNext <= 1'b0;
         o_fire_2    <= 2'b00;
         o_sel       <= SEL_NONE;
      end else begin
         // Pulse outputs default low; only the state that owns them raises them.
         o_free   <= 3'b000;
         o_fire_2 <= 2'b00;
         case (state)
            ST_IDLE: begin
               if (pick_vld) begin
                  o_sel    <= pick_idx;
                  o_fire_2 <= 2'b01;
                  state    <= ST_FIRE0;
               end else begin
                  o_sel <= SEL_NONE;
               end
            end
            ST_FIRE0: begin
               if (GAP_LOAD == 4'd0) begin
                  o_fire_2 <= 2'b10;
                  state    <= ST_FIRE1;
               end else begin
                  gap_cnt <= GAP_LOAD;
                  state   <= ST_GAP0;
               end
            end
            ST_GAP0: begin
               if (gap_cnt == 4'd1) begin
                  gap_cnt  <= 4'd0;
                  o_fire_2 <= 2'b10;
                  state    <= ST_FIRE1;
               end else begin
                  gap_cnt <= gap_cnt - 4'd1;
               end
            end
            ST_FIRE1: begin
               if (GAP_LOAD == 4'd0) begin
                  o_driveNext <= 1'b1;
                  state       <= ST_DRIVE;
               end else begin
                  gap_cnt <= GAP_LOAD;
                  state   <= ST_GAP1;
               end
            end
            ST_GAP1: begin
               if (gap_cnt == 4'd1) begin
                  gap_cnt     <= 4'd0;
                  o_driveNext <= 1'b1;
                  state       <= ST_DRIVE;
               end else begin
                  gap_cnt <= gap_cnt - 4'd1;
               end
            end
            ST_DRIVE: begin
               if (i_freeNext) begin
                  o_driveNext <= 1'b0;
                  o_free      <= 3'b001 << o_sel;
                  state       <= ST_FREE;
               end
            end
            ST_FREE: begin
               ptr   <= next_idx(o_sel);
               o_sel <= SEL_NONE;
               state <= ST_IDLE;
            end
            default: begin
               o_driveNext <= 1'b0;
               o_sel       <= SEL_NONE;
               state       <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_arb_merge3_ctrl.sv
// Bench for arb_merge3_ctrl: FIRE_GAP=0 and FIRE_GAP=3 instances on shared stimulus.
// Latency: checks outputs 1 time unit after each rising edge.
// Backpressure: i_freeNext is driven by table, directed sequences and random stimulus.
module tb_arb_merge3_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] drive = 3'b000;
   logic       fn = 1'b0;

   logic [2:0] free0, free3;
   logic       drv0, drv3;
   logic [1:0] fire0, fire3;
   logic [1:0] sel0, sel3;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   arb_merge3_ctrl #(.FIRE_GAP(0)) dut0 (
      .clk(clk), .rst(rst), .i_drive(drive), .o_free(free0), .o_driveNext(drv0),
      .i_freeNext(fn), .o_fire_2(fire0), .o_sel(sel0)
   );

   arb_merge3_ctrl #(.FIRE_GAP(3)) dut3 (
      .clk(clk), .rst(rst), .i_drive(drive), .o_free(free3), .o_driveNext(drv3),
      .i_freeNext(fn), .o_fire_2(fire3), .o_sel(sel3)
   );

   // Transaction-level reference: offset t counts output cycles since the grant.
   int         gap_of[2] = '{0, 3};
   bit         m_busy[2];
   bit         m_freeing[2];
   int         m_t[2];
   int         m_sel[2];
   int         m_ptr[2];
   logic [2:0] e_free[2];
   logic       e_drv[2];
   logic [1:0] e_fire[2];
   logic [1:0] e_sel[2];

   task automatic model_step(input int k);
      int g;
      bit found;
      g = gap_of[k];
      e_free[k] = 3'b000;
      e_fire[k] = 2'b00;
      e_drv[k]  = 1'b0;
      if (rst) begin
         m_busy[k] = 0; m_freeing[k] = 0; m_ptr[k] = 0; e_sel[k] = 2'b11;
      end else if (m_freeing[k]) begin
         m_ptr[k] = (m_sel[k] + 1) % 3;
         m_busy[k] = 0; m_freeing[k] = 0; e_sel[k] = 2'b11;
      end else if (!m_busy[k]) begin
         found = 0;
         for (int j = 0; j < 3; j++) begin
            int c;
            c = (m_ptr[k] + j) % 3;
            if (!found && drive[c]) begin
               found = 1; m_sel[k] = c;
            end
         end
         if (found) begin
            m_busy[k] = 1; m_t[k] = 1;
            e_fire[k] = 2'b01; e_sel[k] = 2'(m_sel[k]);
         end else begin
            e_sel[k] = 2'b11;
         end
      end else begin
         e_sel[k] = 2'(m_sel[k]);
         if (m_t[k] >= 3 + 2 * g && fn) begin
            m_freeing[k] = 1;
            e_free[k] = 3'(1 << m_sel[k]);
         end else begin
            m_t[k] = m_t[k] + 1;
            e_fire[k] = (m_t[k] == 2 + g) ? 2'b10 : 2'b00;
            e_drv[k]  = (m_t[k] >= 3 + 2 * g);
         end
      end
   endtask

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock: advance DUTs and model, then compare both instances to the model.
   task automatic tick();
      @(posedge clk);
      model_step(0);
      model_step(1);
      #1;
      check("model_gap0", {8'd0, free0, drv0, fire0, sel0},
            {8'd0, e_free[0], e_drv[0], e_fire[0], e_sel[0]});
      check("model_gap3", {8'd0, free3, drv3, fire3, sel3},
            {8'd0, e_free[1], e_drv[1], e_fire[1], e_sel[1]});
   endtask

   typedef struct {
      logic       rst;
      logic [2:0] drv;
      logic       fn;
      logic [2:0] efree;
      logic       edrv;
      logic [1:0] efire;
      logic [1:0] esel;
   } vec_t;

   vec_t tbl[10];

   initial begin
      int f0, f1, dn, ngr, waited;
      logic [1:0] prev;
      logic [1:0] grants[4];
      logic [1:0] want[4];

      // Single requester 1 with FIRE_GAP=0; spurious i_freeNext in FIRE0 and IDLE.
      tbl[0] = '{1'b1, 3'b000, 1'b0, 3'b000, 1'b0, 2'b00, 2'b11};
      tbl[1] = '{1'b0, 3'b010, 1'b0, 3'b000, 1'b0, 2'b01, 2'b01};
      tbl[2] = '{1'b0, 3'b010, 1'b1, 3'b000, 1'b0, 2'b10, 2'b01};
      tbl[3] = '{1'b0, 3'b010, 1'b0, 3'b000, 1'b1, 2'b00, 2'b01};
      tbl[4] = '{1'b0, 3'b010, 1'b0, 3'b000, 1'b1, 2'b00, 2'b01};
      tbl[5] = '{1'b0, 3'b010, 1'b0, 3'b000, 1'b1, 2'b00, 2'b01};
      tbl[6] = '{1'b0, 3'b010, 1'b1, 3'b010, 1'b0, 2'b00, 2'b01};
      tbl[7] = '{1'b0, 3'b000, 1'b0, 3'b000, 1'b0, 2'b00, 2'b11};
      tbl[8] = '{1'b0, 3'b000, 1'b1, 3'b000, 1'b0, 2'b00, 2'b11};
      tbl[9] = '{1'b0, 3'b000, 1'b0, 3'b000, 1'b0, 2'b00, 2'b11};

      for (int r = 0; r < 10; r++) begin
         rst = tbl[r].rst; drive = tbl[r].drv; fn = tbl[r].fn;
         tick();
         check($sformatf("tbl_row%0d", r), {8'd0, free0, drv0, fire0, sel0},
               {8'd0, tbl[r].efree, tbl[r].edrv, tbl[r].efire, tbl[r].esel});
      end

      // FIRE_GAP=3 latency: fire0 at 1, fire1 at 5, driveNext from 9.
      rst = 1'b1; drive = 3'b000; fn = 1'b0;
      tick();
      rst = 1'b0; drive = 3'b001;
      f0 = -1; f1 = -1; dn = -1;
      for (int c = 1; c <= 12; c++) begin
         tick();
         if (fire3[0] && f0 < 0) f0 = c;
         if (fire3[1] && f1 < 0) f1 = c;
         if (drv3 && dn < 0) dn = c;
      end
      check("gap3_fire0_cycle", 16'(f0), 16'd1);
      check("gap3_fire1_cycle", 16'(f1), 16'd5);
      check("gap3_drive_cycle", 16'(dn), 16'd9);
      fn = 1'b1;
      tick();
      check("gap3_free", {13'd0, free3}, 16'h0001);
      tick();

      // Contention with all three held and downstream always ready.
      rst = 1'b1; fn = 1'b0; drive = 3'b000;
      tick();
      rst = 1'b0; drive = 3'b111; fn = 1'b1;
      want[0] = 2'd0; want[1] = 2'd1; want[2] = 2'd2; want[3] = 2'd0;
      ngr = 0; prev = 2'b11;
      for (int c = 0; c < 60 && ngr < 4; c++) begin
         tick();
         if (sel0 != 2'b11 && prev == 2'b11) begin
            grants[ngr] = sel0;
            ngr++;
         end
         prev = sel0;
      end
      check("rr_grant_count", 16'(ngr), 16'd4);
      for (int i = 0; i < ngr; i++)
         check($sformatf("rr_grant%0d", i), {14'd0, grants[i]}, {14'd0, want[i]});

      // Reset during DRIVE abandons the transfer and restarts round-robin at 0.
      rst = 1'b1; fn = 1'b0; drive = 3'b000;
      tick();
      rst = 1'b0; drive = 3'b100;
      waited = 0;
      while (!drv0 && waited < 20) begin
         tick();
         waited++;
      end
      check("rst_reach_drive", {15'd0, drv0}, 16'd1);
      rst = 1'b1; fn = 1'b1;
      tick();
      check("rst_mid_gap0", {8'd0, free0, drv0, fire0, sel0}, {8'd0, 3'b000, 1'b0, 2'b00, 2'b11});
      check("rst_mid_gap3", {8'd0, free3, drv3, fire3, sel3}, {8'd0, 3'b000, 1'b0, 2'b00, 2'b11});
      rst = 1'b0; fn = 1'b0; drive = 3'b111;
      tick();
      check("rst_regrant_sel", {14'd0, sel0}, 16'd0);
      check("rst_regrant_fire", {14'd0, fire0}, 16'd1);

      // Random traffic against the reference model.
      for (int c = 0; c < 3000; c++) begin
         rst   = ($urandom_range(0, 99) == 0);
         drive = 3'($urandom_range(0, 7));
         fn    = 1'($urandom_range(0, 1));
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
